// File: rtl/multiword_add_seq.sv
// -----------------------------------------------------------------------------
// multiword_add_seq
//
// Purpose:
//    Adds two wide operands of N*WORDS bits that arrive as a stream of N-bit
//    word pairs, least-significant word first. The block uses one N-bit slice
//    adder and carries between words in a register. Each accepted word pair
//    produces one result word one cycle later. The result word is held in a
//    single output register with valid/ready handshaking. The last word of an
//    operation is flagged with out_last and carries the final carry-out.
//
// Optional feature:
//    `define MULTIWORD_ADD_SEQ_SUB_EN adds the input port 'sub'. The block
//    samples 'sub' when it accepts word 0 and holds it for the rest of that
//    operation. With sub=1 the block computes A-B as A + ~B + 1, and
//    out_cout=1 then means no borrow occurred. Without the macro there is no
//    sub port, and the block always adds with an initial carry of 0.
//
// Parameters:
//    N      - width of one operand word (slice adder width)
//    WORDS  - words per operand (>= 1)
//
// Ports:
//    clk        in   clock; all state changes on the rising edge
//    rst_n      in   asynchronous active-low reset
//    sub        in   subtract select (only with MULTIWORD_ADD_SEQ_SUB_EN)
//    in_valid   in   an operand word pair is present
//    in_ready   out  the block accepts the word pair this cycle
//    a_word     in   operand A word, LS word first
//    b_word     in   operand B word, LS word first
//    out_valid  out  out_sum holds a result word
//    out_ready  in   the consumer takes the result word
//    out_sum    out  result word
//    out_last   out  out_sum is the MS word of an operation
//    out_cout   out  final carry-out; 0 unless out_last=1
// -----------------------------------------------------------------------------
module multiword_add_seq #(
   parameter int N     = 64,
   parameter int WORDS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
   input  logic         sub,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a_word,
   input  logic [N-1:0] b_word,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sum,
   output logic         out_last,
   output logic         out_cout
);

   // The word counter keeps at least one bit, so WORDS=1 still elaborates.
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,   // no operation in flight; count 0, carry 0
      ST_BUSY = 1'b1    // at least one word of the current operation accepted
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_count;
   logic            r_carry;
   logic            r_out_valid;
   logic [N-1:0]    r_sum;
   logic            r_last;
   logic            r_cout;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
   logic            r_sub;
`endif

   logic            w_in_ready;
   logic            w_accept;
   logic            w_first;
   logic            w_is_last;
   logic            w_cin;
   logic [N-1:0]    w_b_eff;
   logic [N:0]      w_full;

   // Handshake: one output register, so new input is taken only when that
   // register is empty or is being drained in this same cycle.
   always_comb begin
      w_in_ready = !r_out_valid || out_ready;
      w_accept   = in_valid && w_in_ready;
   end

   // Word position: IDLE always means the next accepted word is word 0.
   always_comb begin
      w_first   = (r_state == ST_IDLE);
      w_is_last = (r_count == LAST_IDX);
   end

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
   // Operand conditioning for add/subtract. Word 0 uses the live sub input,
   // and later words use the sub value latched at word 0. Subtraction
   // preloads the carry-in with 1 on word 0 (two's complement of B).
   always_comb begin
      if (w_first) begin
         w_b_eff = sub ? ~b_word : b_word;
         w_cin   = sub;
      end else begin
         w_b_eff = r_sub ? ~b_word : b_word;
         w_cin   = r_carry;
      end
   end
`else
   // Operand conditioning for add only. The carry register is 0 in IDLE, so
   // word 0 naturally starts with a carry-in of 0.
   always_comb begin
      w_b_eff = b_word;
      w_cin   = r_carry;
   end
`endif

   // Slice adder: the N+1-bit result gives the sum word and its carry-out.
   always_comb begin
      w_full = {1'b0, a_word} + {1'b0, w_b_eff} + {{N{1'b0}}, w_cin};
   end

   // Control FSM, the carry chain, and the output register in one place.
   // The last word wraps the count and clears the carry on the same edge,
   // so a following operation can start on the very next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_count     <= {CW{1'b0}};
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
         r_sum       <= {N{1'b0}};
         r_last      <= 1'b0;
         r_cout      <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
         r_sub       <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_sum       <= w_full[N-1:0];
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
            if (w_first) begin
               r_sub <= sub;
            end else begin
               r_sub <= r_sub;
            end
`endif
            if (w_is_last) begin
               r_last  <= 1'b1;
               r_cout  <= w_full[N];
               r_carry <= 1'b0;
               r_count <= {CW{1'b0}};
               r_state <= ST_IDLE;
            end else begin
               r_last  <= 1'b0;
               r_cout  <= 1'b0;
               r_carry <= w_full[N];
               r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
               r_state <= ST_BUSY;
            end
         end else if (r_out_valid && out_ready) begin
            // The consumer took the word and nothing replaced it. The data
            // fields keep their last value; only valid drops.
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_out_valid;
         end
      end
   end

   // Output mapping.
   always_comb begin
      in_ready  = w_in_ready;
      out_valid = r_out_valid;
      out_sum   = r_sum;
      out_last  = r_last;
      out_cout  = r_cout;
   end

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

   localparam int N     = 8;
   localparam int WORDS = 4;

   logic         clk;
   logic         rst_n;
   logic         sub;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a_word;
   logic [N-1:0] b_word;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_sum;
   logic         out_last;
   logic         out_cout;

   int n_pass  = 0;
   int n_total = 0;

   multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      .sub       (sub),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_word    (a_word),
      .b_word    (b_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .out_cout  (out_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Checks the result word of word index idx against the reference sum.
   task automatic check_word(input string tag, input int idx, input logic [32:0] ref_sum);
      logic [7:0] exp_w;
      exp_w = ref_sum[8*idx +: 8];
      check($sformatf("%s.valid%0d", tag, idx), 64'(out_valid), 64'd1);
      check($sformatf("%s.sum%0d", tag, idx), 64'(out_sum), 64'(exp_w));
      check($sformatf("%s.last%0d", tag, idx), 64'(out_last), (idx == WORDS - 1) ? 64'd1 : 64'd0);
      check($sformatf("%s.cout%0d", tag, idx), 64'(out_cout),
            (idx == WORDS - 1) ? 64'(ref_sum[32]) : 64'd0);
   endtask

   // Whole-operand reference: plain 33-bit arithmetic on A and B.
   function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input bit s);
      if (s) return {1'b0, a} + {1'b0, ~b} + 33'd1;
      else   return {1'b0, a} + {1'b0, b};
   endfunction

   // Runs one operation. It must be called at a negedge, and it returns at a
   // negedge with in_valid low, so consecutive calls are back-to-back.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input bit stall);
      logic [32:0] r;
      logic [31:0] av;
      logic [31:0] bv;
      r  = ref_op(a, b, s);
      av = a;
      bv = b;
      for (int i = 0; i < WORDS; i++) begin
         if (i > 0) check_word(tag, i - 1, r);
         a_word   = av[8*i +: 8];
         b_word   = bv[8*i +: 8];
         sub      = s;
         in_valid = 1'b1;
         if (stall && i == 1) begin
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               #1;
               check($sformatf("%s.stall_rdy%0d", tag, k), 64'(in_ready), 64'd0);
               check($sformatf("%s.stall_sum%0d", tag, k), 64'(out_sum), 64'(r[7:0]));
               check($sformatf("%s.stall_vld%0d", tag, k), 64'(out_valid), 64'd1);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
      check_word(tag, WORDS - 1, r);
      in_valid = 1'b0;
      sub      = 1'b0;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] pa;
      bit          rs;

      rst_n     = 1'b0;
      sub       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_word    = 8'h00;
      b_word    = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.sum",   64'(out_sum),   64'd0);
      check("rst.last",  64'(out_last),  64'd0);
      check("rst.cout",  64'(out_cout),  64'd0);
      rst_n = 1'b1;
      #1;
      check("rst.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      // Carry across one word boundary
      do_op("carry1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
      // Full ripple with carry-out
      do_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
      // Back-to-back: no carry leaks into the next operation
      do_op("b2b", 32'h00000001, 32'h00000001, 1'b0, 1'b0);
      // Output stall after the first result
      do_op("stall", 32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b1);

      // Reset in the middle of an operation
      pa = 32'h01FF01FF;
      for (int i = 0; i < 2; i++) begin
         a_word   = pa[8*i +: 8];
         b_word   = 8'h00;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst.valid", 64'(out_valid), 64'd0);
      check("midrst.sum",   64'(out_sum),   64'd0);
      check("midrst.last",  64'(out_last),  64'd0);
      check("midrst.cout",  64'(out_cout),  64'd0);
      check("midrst.ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("postrst", 32'h00000001, 32'h00000001, 1'b0, 1'b0);

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      do_op("sub0m1", 32'h00000000, 32'h00000001, 1'b1, 1'b0);
      do_op("sub5m3", 32'h00000005, 32'h00000003, 1'b1, 1'b0);
`endif

      // Randomized operations, back-to-back, occasionally stalled
      for (int t = 0; t < 12; t++) begin
         ra = $urandom();
         rb = $urandom();
         rs = 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
         rs = 1'($urandom_range(0, 1));
`endif
         do_op($sformatf("rnd%0d", t), ra, rb, rs, ($urandom_range(0, 3) == 0));
      end

      // Idle after the last take: valid drops
      @(negedge clk);
      check("idle.valid", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter N, default 64: width of one operand word (slice adder width).
REQ-002 SHALL have parameter WORDS, default 4: words per operand; WORDS >= 1; full operand width = N*WORDS.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand word pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts the word pair this cycle.
REQ-007 SHALL have port a_word  input  N  operand A word, least-significant word first.
REQ-008 SHALL have port b_word  input  N  operand B word, least-significant word first.
REQ-009 SHALL have port out_valid  output  1  out_sum holds a result word.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result word.
REQ-011 SHALL have port out_sum  output  N  result word.
REQ-012 SHALL have port out_last  output  1  out_sum is the most-significant word of an operation.
REQ-013 SHALL have port out_cout  output  1  final carry-out; meaningful only when out_last=1, else 0.

Function
REQ-014 SHALL perform accept on a cycle where in_valid=1 and in_ready=1; no other cycle changes word count or carry.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (single output register, no skid buffer).
REQ-016 SHALL compute per accepted word {c, s} = a_word + b_word + carry_reg, N+1-bit result, with s registered into out_sum on the accept edge.
REQ-017 SHALL have latency of exactly 1 cycle: result word valid the cycle after its accept.
REQ-018 SHALL hold out_sum, out_last, out_cout, out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL clear out_valid on a cycle with out_valid=1, out_ready=1 and no accept; simultaneous take and accept reloads the register, and out_valid stays 1.
REQ-020 SHALL use a two-state FSM: IDLE (word count 0, carry_reg 0) and BUSY (mid-operand).
REQ-021 SHALL transition IDLE->BUSY on accept when WORDS>1; BUSY->BUSY on accept with count < WORDS-1; BUSY->IDLE on accept of word WORDS-1.
REQ-022 SHALL, on accept of the last word, set out_last=1 and out_cout=c, and clear carry_reg to 0 and wrap the count to 0 in the same edge.
REQ-023 SHALL, for WORDS=1, remain in IDLE and mark every accepted word last.
REQ-024 SHALL, otherwise, update carry_reg to c on each non-last accept.
REQ-025 SHALL accept back-to-back operations with no idle cycle between the last word of one operation and the first word of the next.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force IDLE, count 0, carry_reg 0, out_valid 0, out_sum 0, out_last 0, out_cout 0.
REQ-027 SHALL discard a partially accepted operation when reset asserts mid-operation; the first accept after release is word 0 of a new operation.
REQ-028 SHALL drive in_ready=1 from reset release, since out_valid=0.

Configuration
REQ-029 SHALL, with macro MULTIWORD_ADD_SEQ_SUB_EN defined, add input port sub (1 bit, sampled on word 0 accept and held for the operation).
REQ-030 SHALL, with sub=1, compute A-B: b_word inverted on every word and carry_reg preloaded to 1 for word 0; out_cout=1 means no borrow.
REQ-031 SHALL, without MULTIWORD_ADD_SEQ_SUB_EN, have no sub port and always add with initial carry 0.

Verification (N=8, WORDS=4)
REQ-032 SHALL verify: A=0x000000FF, B=0x00000001, out_ready=1 -> words 0x00,0x01,0x00,0x00, last on 4th, cout=0.
REQ-033 SHALL verify: A=0xFFFFFFFF, B=0x00000001 -> all words 0x00, out_cout=1 with out_last.
REQ-034 SHALL verify: out_ready=0 for 3 cycles after first result -> in_ready=0, out_sum held, no word lost, sequence resumes intact.
REQ-035 SHALL verify: reset pulse after 2 words of A=0x01FF01FF -> outputs 0; next operation 0x00000001+0x00000001 -> 0x02,0x00,0x00,0x00.
REQ-036 SHALL verify: back-to-back ops 0xFFFFFFFF+0x1 then 0x1+0x1 -> second op word 0 = 0x02, with no carry leaked from the first op.
REQ-037 SHALL verify, with MULTIWORD_ADD_SEQ_SUB_EN defined: sub=1, A=0x00000000, B=0x00000001 -> words 0xFF x4, cout=0; A=5, B=3 -> 0x02,0x00,0x00,0x00, cout=1.
